// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the sequenced ALU.
package alu_seq_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_NOT = 5;
    localparam int unsigned OP_MOV = 6;
    localparam int unsigned OP_INC = 7;
    localparam int unsigned OP_DEC = 8;
    localparam int unsigned OP_MUL = 9;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, single-cycle done pulse when the
// 2*WIDTH product is final. The first bit is consumed at the start edge.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    import alu_seq_pkg::*;

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else if (start) begin
            mcand   <= PW'(a) << 1;
            product <= b[0] ? PW'(a) : '0;
            mplier  <= b >> 1;
            cnt     <= CNT_W'(WIDTH - 1);
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready input and held output handshake.
// Define ALU_SEQ_MUL_EN to enable the multi-cycle multiply on opcode 9.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    import alu_seq_pkg::*;

    localparam int unsigned MSB = WIDTH - 1;

    state_t         state;
    logic           accept_c;
    logic [WIDTH-1:0] rhs_c;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH:0]   ext_c;
    logic           add_c;
    logic           sub_c;
    logic           legal_c;
    logic           carry_c;
    logic           ovf_c;
    logic [3:0]     flags_c;

    assign accept_c = in_valid && in_ready;

    // Single-cycle datapath; ADD/SUB/INC/DEC share one (WIDTH+1)-bit adder.
    always_comb begin
        rhs_c   = b;
        res_c   = '0;
        ext_c   = '0;
        add_c   = 1'b0;
        sub_c   = 1'b0;
        legal_c = 1'b1;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        flags_c = '0;
        case (op)
            OP_W'(OP_ADD): add_c = 1'b1;
            OP_W'(OP_SUB): sub_c = 1'b1;
            OP_W'(OP_INC): begin add_c = 1'b1; rhs_c = WIDTH'(1); end
            OP_W'(OP_DEC): begin sub_c = 1'b1; rhs_c = WIDTH'(1); end
            OP_W'(OP_AND): res_c = a & b;
            OP_W'(OP_OR):  res_c = a | b;
            OP_W'(OP_XOR): res_c = a ^ b;
            OP_W'(OP_NOT): res_c = ~a;
            OP_W'(OP_MOV): res_c = a;
            default:       legal_c = 1'b0;
        endcase
        if (add_c) begin
            ext_c   = {1'b0, a} + {1'b0, rhs_c};
            res_c   = ext_c[WIDTH-1:0];
            carry_c = ext_c[WIDTH];
            ovf_c   = (a[MSB] == rhs_c[MSB]) && (res_c[MSB] != a[MSB]);
        end else if (sub_c) begin
            ext_c   = {1'b0, a} - {1'b0, rhs_c};
            res_c   = ext_c[WIDTH-1:0];
            carry_c = ~ext_c[WIDTH];
            ovf_c   = (a[MSB] != rhs_c[MSB]) && (res_c[MSB] != a[MSB]);
        end
        if (legal_c) begin
            flags_c[FLAG_N] = res_c[MSB];
            flags_c[FLAG_Z] = (res_c == '0);
            flags_c[FLAG_C] = carry_c;
            flags_c[FLAG_V] = ovf_c;
        end else begin
            res_c = '0;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign mul_start = accept_c && (op == OP_W'(OP_MUL));

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        in_ready <= 1'b0;
                        result   <= res_c;
                        flags    <= flags_c;
`ifdef ALU_SEQ_MUL_EN
                        if (op == OP_W'(OP_MUL)) begin
                            state <= EXEC;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
`else
                        state     <= DONE;
                        out_valid <= 1'b1;
`endif
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                EXEC: begin
                    if (mul_done) begin
                        state          <= DONE;
                        out_valid      <= 1'b1;
                        result         <= mul_product[WIDTH-1:0];
                        flags[FLAG_N]  <= mul_product[MSB];
                        flags[FLAG_Z]  <= (mul_product[WIDTH-1:0] == '0);
                        flags[FLAG_C]  <= |mul_product[2*WIDTH-1:WIDTH];
                        flags[FLAG_V]  <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at WIDTH=8 (honours ALU_SEQ_MUL_EN).
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int tests  = 0;
    int errors = 0;

    alu_seq_unit #(.WIDTH(8), .OP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency to out_valid, check payload, then consume it.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int exp_lat,
                          input logic [7:0] exp_res, input logic [3:0] exp_flags);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " flags"}, 32'(flags), 32'(exp_flags));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        rst = 1'b0;
        tick();

        // Add with a held output: payload must not move while unconsumed.
        op = 4'd0; a = 8'h22; b = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold valid", 32'(out_valid), 32'd1);
            check("hold result", 32'(result), 32'h33);
            check("hold flags", 32'(flags), 32'h0);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add drained", 32'({out_valid, in_ready}), 32'b01);

        // Flags are {N,Z,C,V}.
        run_op("sub",     4'd1,  8'h11, 8'h22, 1, 8'hEF, 4'b1000);
        run_op("sub ovf", 4'd1,  8'h80, 8'h01, 1, 8'h7F, 4'b0011);
        run_op("add ovf", 4'd0,  8'h7F, 8'h01, 1, 8'h80, 4'b1001);
        run_op("add cy",  4'd0,  8'hFF, 8'h01, 1, 8'h00, 4'b0110);
        run_op("and",     4'd2,  8'hF0, 8'h3C, 1, 8'h30, 4'b0000);
        run_op("or",      4'd3,  8'hF0, 8'h0F, 1, 8'hFF, 4'b1000);
        run_op("xor",     4'd4,  8'hAA, 8'hAA, 1, 8'h00, 4'b0100);
        run_op("not",     4'd5,  8'h22, 8'h00, 1, 8'hDD, 4'b1000);
        run_op("mov",     4'd6,  8'h80, 8'h55, 1, 8'h80, 4'b1000);
        run_op("inc",     4'd7,  8'hFF, 8'h00, 1, 8'h00, 4'b0110);
        run_op("dec",     4'd8,  8'h00, 8'h00, 1, 8'hFF, 4'b1000);
        run_op("illegal", 4'd12, 8'h5A, 8'hA5, 1, 8'h00, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul",     4'd9,  8'h12, 8'h10, 9, 8'h20, 4'b0010);
        run_op("mul z",   4'd9,  8'h00, 8'h37, 9, 8'h00, 4'b0100);
`else
        run_op("mul off", 4'd9,  8'h12, 8'h10, 1, 8'h00, 4'b0000);
`endif

        // Second request held high during DONE is only taken after the consume edge.
        op = 4'd0; a = 8'h05; b = 8'h06; in_valid = 1'b1;
        tick();
        a = 8'h01; b = 8'h02;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp result", 32'(result), 32'h0B);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp consume", 32'({out_valid, in_ready}), 32'b01);
        tick();
        in_valid = 1'b0;
        check("bp second valid", 32'(out_valid), 32'd1);
        check("bp second result", 32'(result), 32'h03);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset four cycles into a multiply aborts it immediately.
        op = 4'd9; a = 8'h12; b = 8'h10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op("post rst", 4'd0, 8'h01, 8'h01, 1, 8'h02, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
